serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single one-bit full adder, `fa_dataflow`, over WIDTH cycles to add two WIDTH-bit operands with carry-in. It latches the operands on a start pulse and shifts them LSB-first through the full adder. A registered carry feeds back between bits. The shifted-out sum is collected and reported with a one-cycle done pulse. It sits between a requesting datapath and the shared 1-bit adder, trading latency for area.

---
 rtl/serial_add_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller driving one shared 1-bit full adder.
//   It latches the operands on an accepted start and adds them LSB-first over
//   WIDTH RUN cycles. The carry is registered between bits.
// Latency: the start edge plus WIDTH RUN edges, then a one-cycle done pulse.
//   Throughput is one operation per WIDTH+2 cycles.
// Backpressure: none. start is sampled only in IDLE and is ignored in RUN and
//   DONE; requests are not queued.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   start, a, b, ci        request and operands, latched on an accepted start
//   busy, done             state decodes (busy=RUN, done=DONE)
//   sum, co                result; valid from done until the next accepted start
//   ovf                    signed overflow, present only when SERIAL_ADD_OVF_EN is defined
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the ovf port and the cmsb register).

// One-bit full adder; the only adder logic in the design.
module fa_dataflow (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_s;
  logic             w_fa_co;
  logic             w_accept;
  logic             w_last;

  fa_dataflow u_fa (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .ci (r_carry),
    .s  (w_fa_s),
    .co (w_fa_co)
  );

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_cnt == LAST_BIT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand shifters, carry feedback, bit counter and sum collector.
  // In DONE and IDLE (without start) everything holds, which keeps sum/co
  // stable until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= b;
      r_sum   <= '0;
      r_carry <= ci;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
      // Each new sum bit enters at the MSB end, so after WIDTH shifts
      // bit 0 of the result has reached position 0.
      r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
      r_carry <= w_fa_co;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_cmsb;

  // Carry into the MSB. The start value equals ci, so ovf reads 0 right
  // after an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmsb <= 1'b0;
    end else if (w_accept) begin
      r_cmsb <= ci;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_cmsb <= r_carry;
    end
  end

  // Two's-complement overflow: carry into MSB differs from carry out.
  // It is masked during RUN, where r_carry is still moving.
  assign ovf = (r_state != ST_RUN) & (r_cmsb ^ r_carry);
`endif

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign co   = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         done_seen = 0;
  int         n_ops     = 0;
  logic [9:0] sb_q[$];
  logic [9:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, co, sum} from plain integer addition.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] s;
    logic       ov;
    s  = {1'b0, x} + {1'b0, y} + {8'd0, c};
    ov = (x[7] == y[7]) && (s[7] != x[7]);
    return {ov, s[8], s[7:0]};
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", sb_q.size(), 1);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_sum", sum, mon_exp[7:0]);
        chk("sb_co", co, mon_exp[8]);
`ifdef SERIAL_ADD_OVF_EN
        chk("sb_ovf", ovf, mon_exp[9]);
`endif
      end
    end
  end

  // repulse_c: RUN cycle in which start is re-pulsed with a=8'h11 (-1 = none).
  // abort_c:   RUN cycle in which rst_n is pulled low mid-cycle (-1 = none).
  task automatic run_op(input logic [7:0] a_i, input logic [7:0] b_i, input logic ci_i,
                        input int repulse_c, input int abort_c);
    logic [9:0] exp;
    int         busy_n;
    int         done_k;
    int         dseen0;
    bit         got;
    exp    = model(a_i, b_i, ci_i);
    busy_n = 0;
    done_k = -1;
    got    = 1'b0;
    dseen0 = done_seen;
    @(posedge clk); #1;
    a = a_i; b = b_i; ci = ci_i; start = 1'b1;
    if (abort_c < 0) begin
      sb_q.push_back(exp);
      n_ops++;
    end
    @(posedge clk); #1;  // E0 accepted
    start = 1'b0;
    for (int k = 0; k < 3 * W && !got; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k + 1 == repulse_c + 1) begin
        start = 1'b0;
        a     = a_i;
      end
      if (done) begin
        got    = 1'b1;
        done_k = k;
      end else if (busy) begin
        busy_n++;
      end
      if (k + 1 == repulse_c) begin
        start = 1'b1;
        a     = 8'h11;
      end
      if (k + 1 == abort_c) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_co", co, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2 * W) @(posedge clk);
        #1;
        chk("abort_no_done", done_seen, dseen0);
        return;
      end
    end
    chk("done_seen", got, 1);
    chk("busy_cycles", busy_n, W);
    chk("done_edge", done_k, W);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", sum, exp[7:0]);
    chk("hold_co", co, exp[8]);
`ifdef SERIAL_ADD_OVF_EN
    chk("hold_ovf", ovf, exp[9]);
`endif
    chk("done_pulses", done_seen - dseen0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", co, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op(8'h35, 8'h0A, 1'b0, -1, -1);
    run_op(8'hFF, 8'h01, 1'b0, -1, -1);
    run_op(8'hFF, 8'hFF, 1'b1, -1, -1);
    run_op(8'h7F, 8'h01, 1'b0, -1, -1);
    run_op(8'h80, 8'h80, 1'b0, -1, -1);
    run_op(8'h35, 8'h0A, 1'b0, 3, -1);   // re-pulse in RUN is ignored
    run_op(8'h35, 8'h0A, 1'b0, -1, 4);   // reset mid-RUN aborts
    run_op(8'h01, 8'h02, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), -1, -1);
    end

    chk("total_done_pulses", done_seen, n_ops);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
